// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner
//   Scans a ROWS x COLS switch matrix by strobing one row at a time and
//   sensing the column lines. It debounces whole scan frames and hands
//   accepted key presses to a consumer through a valid/ready event port.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   col_in     [COLS-1:0]   column sense lines, active-high, asynchronous
//   row_drive  [ROWS-1:0]   one-hot row strobe; bit ROWS-1 is row 0
//   key_code   [CODE_W-1:0] event key index = row*COLS + col
//   key_valid  key_code holds an unconsumed event
//   key_ready  consumer accepts the event
//   key_rpt    current event is an auto-repeat
//   key_held   a debounced key is currently down
//   overrun    sticky, an event was dropped (cleared only by rst)
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a key held down re-emits its code with
//                     key_rpt=1 every REPEAT_FRAMES frames. When undefined,
//                     no repeat logic exists and key_rpt is constant 0.
module matrix_keypad_scanner #(
  parameter int ROWS          = 4,
  parameter int COLS          = 3,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 64,
  localparam int CODE_W = ($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_rpt,
  output logic              key_held,
  output logic              overrun
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Hit counts saturate at 2: the frame logic only distinguishes none, one
  // and "more than one".
  function automatic logic [1:0] sat_hits(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [COLS-1:0]   col_sync_p0, col_sync_p1;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [RW-1:0]     row_idx;
  logic              frame_end;
  logic [1:0]        acc_hits;
  logic [CODE_W-1:0] acc_code;
  logic [1:0]        row_hits;
  int                row_col;
  logic [CODE_W-1:0] row_code;
  logic [1:0]        frame_hits;
  logic [CODE_W-1:0] frame_code;
  logic [1:0]        state, state_n;
  logic [CODE_W-1:0] cand, cand_n;
  logic [3:0]        cnt, cnt_n;
  logic              emit;
  logic              ev_go;
  logic              load;

  // ---- stage p0/p1: two-flop synchronizer, prescaler, row strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      col_sync_p0 <= '0;
      col_sync_p1 <= '0;
      presc       <= '0;
      row_drive   <= {1'b1, {(ROWS-1){1'b0}}};
      row_idx     <= '0;
    end else begin
      col_sync_p0 <= col_in;
      col_sync_p1 <= col_sync_p0;
      presc       <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        row_drive <= {row_drive[0], row_drive[ROWS-1:1]};
        row_idx   <= frame_end ? '0 : row_idx + 1'b1;
      end
    end
  end

  assign tick      = (presc == PW'(SCAN_DIV-1));
  assign frame_end = tick && (row_idx == RW'(ROWS-1));

  // Classify the current row sample and merge it into the running frame.
  // The lowest set column is kept; it only matters when exactly one is set.
  always_comb begin
    row_hits = 2'd0;
    row_col  = 0;
    for (int j = COLS-1; j >= 0; j--) begin
      if (col_sync_p1[j]) begin
        row_hits = sat_hits(row_hits, 2'd1);
        row_col  = j;
      end
    end
    row_code   = CODE_W'(int'(row_idx) * COLS + row_col);
    frame_hits = sat_hits(acc_hits, row_hits);
    frame_code = (acc_hits == 2'd0) ? row_code : acc_code;
  end

  // ---- stage p2: frame accumulator and debounce state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hits <= '0;
      acc_code <= '0;
      state    <= S_IDLE;
      cand     <= '0;
      cnt      <= '0;
    end else begin
      if (tick) begin
        acc_hits <= frame_end ? 2'd0 : frame_hits;
        acc_code <= frame_end ? '0 : frame_code;
      end
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    emit    = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (frame_hits == 2'd1) begin
            cand_n = frame_code;
            if (DB == 4'd1) begin
              state_n = S_PRESSED;
              cnt_n   = '0;
              emit    = 1'b1;
            end else begin
              state_n = S_DEBOUNCE;
              cnt_n   = 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_hits == 2'd1 && frame_code == cand) begin
            if (cnt + 4'd1 == DB) begin
              state_n = S_PRESSED;
              cnt_n   = '0;
              emit    = 1'b1;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
        S_PRESSED: begin
          // A different single key or extra keys never re-arm; only a
          // debounced release does.
          if (frame_hits == 2'd0) begin
            if (DB == 4'd1) begin
              state_n = S_IDLE;
              cnt_n   = '0;
            end else begin
              state_n = S_RELEASE;
              cnt_n   = 4'd1;
            end
          end
        end
        default: begin
          if (frame_hits == 2'd0) begin
            if (cnt + 4'd1 == DB) begin
              state_n = S_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            state_n = S_PRESSED;
            cnt_n   = '0;
          end
        end
      endcase
    end
  end

  assign key_held = (state == S_PRESSED) || (state == S_RELEASE);

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_FRAMES + 1);

  logic [RPW-1:0] rpt_cnt, rpt_cnt_n;
  logic           rpt_fire;

  // Counts frames spent continuously in PRESSED; any other frame outcome
  // (entry, release, pause) restarts the count from zero.
  always_comb begin
    rpt_cnt_n = rpt_cnt;
    rpt_fire  = 1'b0;
    if (frame_end) begin
      if (state == S_PRESSED && frame_hits != 2'd0) begin
        if (rpt_cnt == RPW'(REPEAT_FRAMES-1)) begin
          rpt_fire  = 1'b1;
          rpt_cnt_n = '0;
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end else begin
        rpt_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt <= '0;
      key_rpt <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt_n;
      if (load) key_rpt <= rpt_fire;
    end
  end

  assign ev_go = emit | rpt_fire;
`else
  assign key_rpt = 1'b0;
  assign ev_go   = emit;
`endif

  // ---- event port: load when empty or being drained this edge ----
  assign load = ev_go && (!key_valid || key_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        key_valid <= 1'b1;
        key_code  <= cand_n;
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
      if (ev_go && key_valid && !key_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
module tb_matrix_keypad_scanner;

  localparam int ROWS          = 4;
  localparam int COLS          = 3;
  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE      = 2;
  localparam int REPEAT_FRAMES = 3;
  localparam int CODE_W        = 4;
  localparam int NKEYS         = ROWS * COLS;
  localparam int FRAME         = ROWS * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [COLS-1:0]   col_in;
  logic [ROWS-1:0]   row_drive;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              key_rpt;
  logic              key_held;
  logic              overrun;

  logic [NKEYS-1:0]  keys;

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_drive(row_drive),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_rpt(key_rpt), .key_held(key_held), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical switch matrix: a closed switch connects its row strobe to its
  // column line. Row r is driven by row_drive bit ROWS-1-r.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_drive[ROWS-1-r])
        for (int c = 0; c < COLS; c++)
          if (keys[r*COLS + c]) col_in[c] = 1'b1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit m_down;
  int m_arm, m_quiet, m_key, m_since;
  bit m_valid, m_rpt, m_ovr;
  int m_code;

  task automatic model_reset();
    m_down = 0; m_arm = 0; m_quiet = 0; m_key = 0; m_since = 0;
    m_valid = 0; m_rpt = 0; m_ovr = 0; m_code = 0;
  endtask

  task automatic model_frame(input logic [NKEYS-1:0] k, input bit rdy);
    int n, c;
    bit ev, evr;
    n = $countones(k);
    c = 0;
    for (int i = 0; i < NKEYS; i++) if (k[i]) c = i;
    ev = 0; evr = 0;
    if (!m_down) begin
      if (m_arm == 0) begin
        if (n == 1) begin m_key = c; m_arm = 1; end
      end else if (n == 1 && c == m_key) begin
        m_arm++;
      end else begin
        m_arm = 0;
      end
      if (m_arm >= DEBOUNCE) begin
        m_down = 1; m_arm = 0; m_quiet = 0; m_since = 0; ev = 1;
      end
    end else if (n == 0) begin
      m_quiet++; m_since = 0;
      if (m_quiet >= DEBOUNCE) begin m_down = 0; m_quiet = 0; end
    end else if (m_quiet > 0) begin
      m_quiet = 0; m_since = 0;
    end else begin
      m_since++;
      if (REP_EN && m_since >= REPEAT_FRAMES) begin
        m_since = 0; ev = 1; evr = 1;
      end
    end
    if (rdy) m_valid = 0;
    if (ev) begin
      if (!m_valid) begin m_valid = 1; m_code = m_key; m_rpt = evr; end
      else m_ovr = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Reset for one edge and check every output; that edge starts frame 0.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_row_drive", int'(row_drive), 8);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code",  int'(key_code), 0);
    check("rst_key_rpt",   int'(key_rpt), 0);
    check("rst_key_held",  int'(key_held), 0);
    check("rst_overrun",   int'(overrun), 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Called #1 after a frame-boundary edge; ends #1 after the next one.
  task automatic run_frame(input logic [NKEYS-1:0] k, input bit rdy);
    keys = k;
    key_ready = rdy;
    repeat (FRAME) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NKEYS-1:0] k;
    bit               valid;
    int               code;
    bit               held;
  } vec_t;

  function automatic vec_t mk(input logic [NKEYS-1:0] k, input bit v, input int code, input bit h);
    vec_t t;
    t.k = k; t.valid = v; t.code = code; t.held = h;
    return t;
  endfunction

  vec_t tbl[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NKEYS-1:0] k, prev;
    int a, b;
    bit rdy, exp_v;

    rst = 1'b1;
    keys = '0;
    key_ready = 1'b1;

    // press/release, bounce, two-key, other-key-while-held and re-press
    tbl[0]  = mk(12'h010, 0, 0, 0);
    tbl[1]  = mk(12'h010, 1, 4, 1);
    tbl[2]  = mk(12'h010, 0, 0, 1);
    tbl[3]  = mk(12'h000, 0, 0, 1);
    tbl[4]  = mk(12'h000, 0, 0, 0);
    tbl[5]  = mk(12'h020, 0, 0, 0);
    tbl[6]  = mk(12'h000, 0, 0, 0);
    tbl[7]  = mk(12'h021, 0, 0, 0);
    tbl[8]  = mk(12'h021, 0, 0, 0);
    tbl[9]  = mk(12'h021, 0, 0, 0);
    tbl[10] = mk(12'h021, 0, 0, 0);
    tbl[11] = mk(12'h021, 0, 0, 0);
    tbl[12] = mk(12'h200, 0, 0, 0);
    tbl[13] = mk(12'h200, 1, 9, 1);
    tbl[14] = mk(12'h208, 0, 0, 1);
    tbl[15] = mk(12'h008, 0, 0, 1);
    tbl[16] = mk(12'h000, 0, 0, 1);
    tbl[17] = mk(12'h200, 0, 0, 1);
    tbl[18] = mk(12'h000, 0, 0, 1);
    tbl[19] = mk(12'h000, 0, 0, 0);

    // Idle scanning: row strobe walks 1000,0100,0010,0001, SCAN_DIV clocks each
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      check("scan_row_drive", int'(row_drive), 8 >> ((c / SCAN_DIV) % ROWS));
      check("scan_key_valid", int'(key_valid), 0);
      check("scan_key_held",  int'(key_held), 0);
    end

    // Table of frame-by-frame vectors
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_frame(tbl[i].k, 1'b1);
      check("tbl_key_valid", int'(key_valid), int'(tbl[i].valid));
      check("tbl_key_held",  int'(key_held), int'(tbl[i].held));
      if (tbl[i].valid) begin
        check("tbl_key_code", int'(key_code), tbl[i].code);
        check("tbl_key_rpt",  int'(key_rpt), 0);
      end
    end
    check("tbl_overrun", int'(overrun), 0);

    // Backpressure: code 2 held, second press (code 7) is dropped
    do_reset();
    run_frame(12'h004, 1'b0);
    run_frame(12'h004, 1'b0);
    check("bp_first_valid", int'(key_valid), 1);
    check("bp_first_code",  int'(key_code), 2);
    run_frame(12'h000, 1'b0);
    run_frame(12'h000, 1'b0);
    check("bp_released_held", int'(key_held), 0);
    run_frame(12'h080, 1'b0);
    run_frame(12'h080, 1'b0);
    check("bp_still_valid", int'(key_valid), 1);
    check("bp_code_stable", int'(key_code), 2);
    check("bp_overrun",     int'(overrun), 1);
    key_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drained_valid", int'(key_valid), 0);
    @(posedge clk); #1;
    check("bp_one_transfer",  int'(key_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Long hold of code 11: press at frame 2, repeats only with the option
    do_reset();
    for (int f = 1; f <= 10; f++) begin
      run_frame(12'h800, 1'b1);
      exp_v = (f == 2) || (REP_EN && (f == 5 || f == 8));
      check("hold_key_valid", int'(key_valid), int'(exp_v));
      check("hold_key_held",  int'(key_held), int'(f >= 2));
      if (exp_v) begin
        check("hold_key_code", int'(key_code), 11);
        check("hold_key_rpt",  int'(key_rpt), int'(f != 2));
      end
    end

    // Reset in the middle of a debounce
    do_reset();
    run_frame(12'h010, 1'b1);
    check("mid_deb_valid", int'(key_valid), 0);
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    run_frame(12'h010, 1'b1);
    check("post_rst_deb1_valid", int'(key_valid), 0);
    run_frame(12'h010, 1'b1);
    check("post_rst_deb2_valid", int'(key_valid), 1);
    check("post_rst_deb2_code",  int'(key_code), 4);

    // Reset while an event is pending
    do_reset();
    run_frame(12'h010, 1'b0);
    run_frame(12'h010, 1'b0);
    check("pend_valid", int'(key_valid), 1);
    do_reset();
    run_frame(12'h010, 1'b0);
    check("pend_cleared_valid", int'(key_valid), 0);
    run_frame(12'h010, 1'b0);
    check("pend_fresh_valid", int'(key_valid), 1);
    check("pend_fresh_code",  int'(key_code), 4);

    // Randomized frames against the reference model
    do_reset();
    prev = '0;
    for (int f = 0; f < 160; f++) begin
      a = $urandom_range(0, 99);
      if (a < 50) k = prev;
      else if (a < 68) k = '0;
      else if (a < 90) begin
        k = '0;
        k[$urandom_range(0, NKEYS-1)] = 1'b1;
      end else begin
        k = '0;
        a = $urandom_range(0, NKEYS-1);
        b = (a + 1 + $urandom_range(0, NKEYS-2)) % NKEYS;
        k[a] = 1'b1;
        k[b] = 1'b1;
      end
      prev = k;
      rdy = ($urandom_range(0, 3) != 0);
      run_frame(k, rdy);
      model_frame(k, rdy);
      check("rnd_key_valid", int'(key_valid), int'(m_valid));
      check("rnd_key_held",  int'(key_held), int'(m_down));
      check("rnd_overrun",   int'(overrun), int'(m_ovr));
      if (m_valid) begin
        check("rnd_key_code", int'(key_code), m_code);
        check("rnd_key_rpt",  int'(key_rpt), int'(m_rpt));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of driven row lines, range 2..8.
REQ-002 Parameter COLS, default 3: number of sensed column lines, range 1..8.
REQ-003 Parameter SCAN_DIV, default 1000: clk cycles per scan step, minimum 2.
REQ-004 Parameter DEBOUNCE, default 4: consecutive identical scan frames required to accept a press or a release, range 1..15.
REQ-005 Parameter REPEAT_FRAMES, default 64: frames between repeat events, used only when KEYPAD_REPEAT_EN is defined.
REQ-006 Localparam CODE_W = max(1, clog2(ROWS*COLS)).
REQ-007 clk  input  1  sole clock, all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 col_in  input  COLS  column sense lines, active-high, asynchronous to clk.
REQ-010 row_drive  output  ROWS  one-hot row strobe, active-high.
REQ-011 key_code  output  CODE_W  accepted key index = row_index*COLS + col_index; row_index 0 is bit ROWS-1 of row_drive.
REQ-012 key_valid  output  1  key_code holds an unconsumed event.
REQ-013 key_ready  input  1  consumer accepts event.
REQ-014 key_rpt  output  1  current event is an auto-repeat, not an initial press.
REQ-015 key_held  output  1  a debounced key is currently down.
REQ-016 overrun  output  1  sticky: an event was dropped.

Function
REQ-017 col_in SHALL pass through a 2-flop synchronizer before any use.
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 and raise a one-cycle tick at SCAN_DIV-1, then wrap to 0.
REQ-019 On each tick the synchronized columns SHALL be sampled for the currently driven row, then row_drive SHALL rotate one bit toward LSB, bit 0 wrapping to bit ROWS-1.
REQ-020 A frame SHALL be ROWS consecutive ticks starting at row_index 0; frame result is NONE (no bits set), SINGLE(code) (exactly one bit set in the whole frame) or MULTI (two or more).
REQ-021 State machine states IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated once per completed frame.
REQ-022 IDLE: SINGLE(c) -> DEBOUNCE, candidate=c, count=1 (if DEBOUNCE=1 go directly to PRESSED and emit); NONE/MULTI -> stay.
REQ-023 DEBOUNCE: SINGLE(candidate) -> count+1, on reaching DEBOUNCE -> PRESSED and emit press event; any other result -> IDLE.
REQ-024 PRESSED: SINGLE(candidate) or MULTI -> stay; NONE -> RELEASE, count=1; SINGLE(other) -> stay (no new event until release).
REQ-025 RELEASE: NONE -> count+1, on reaching DEBOUNCE -> IDLE; any key seen -> PRESSED without new event.
REQ-026 key_held SHALL be 1 in PRESSED and RELEASE, 0 otherwise.
REQ-027 Emitting with key_valid=0 SHALL load key_code/key_rpt and set key_valid on the next edge.
REQ-028 Transfer occurs on an edge with key_valid=1 and key_ready=1; key_valid then clears unless an event is emitted in the same cycle, in which case the new event loads and key_valid stays 1.
REQ-029 Emitting with key_valid=1 and key_ready=0 SHALL keep the held event unchanged, drop the new one and set overrun.
REQ-030 key_code and key_rpt SHALL stay stable while key_valid=1 and not transferred.

Reset
REQ-031 With rst=1 at an edge: row_drive=1<<(ROWS-1), prescaler=0, synchronizer=0, state=IDLE, counters=0, key_code=0, key_valid=0, key_rpt=0, key_held=0, overrun=0.
REQ-032 Reset mid-frame or mid-debounce SHALL discard partial frame and pending event; overrun clears only on reset.

Configuration
REQ-033 Macro KEYPAD_REPEAT_EN defined: in PRESSED, after REPEAT_FRAMES frames since entry or since last repeat, emit event with same code and key_rpt=1; RELEASE pauses and resets the repeat counter.
REQ-034 Macro undefined: no repeat logic synthesized, key_rpt tied 0, REPEAT_FRAMES ignored.

Verification (ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=2, REPEAT_FRAMES=3)
REQ-035 Reset, no keys, 100 cycles -> row_drive cycles 1000,0100,0010,0001 every 4 clk, key_valid=0, key_held=0.
REQ-036 Hold col_in=3'b010 only while row_drive=0100 for 3 frames, key_ready=1 -> one key_valid pulse, key_code=4, key_held=1; release for 2 frames -> key_held=0.
REQ-037 Key down 1 frame then up -> no key_valid; two keys down (codes 0 and 5) 5 frames -> no event.
REQ-038 key_ready=0, press code 2, release, press code 7 -> key_code stays 2, overrun=1; key_ready=1 -> one transfer, key_valid=0.
REQ-039 KEYPAD_REPEAT_EN defined, hold code 11 for 10 frames, key_ready=1 -> press event key_rpt=0 then repeats key_rpt=1 every 3 frames; undefined -> single event only.
REQ-040 Assert rst during DEBOUNCE and with key_valid=1 -> all outputs at REQ-031 values next edge, no event emitted afterward without a fresh full debounce.
